// File: rtl/spi_pkg.sv
// Shared SPI definitions: widths, command encodings and the master FSM state type.
// The slave side uses the same command constants.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CMD_W  = 2;
    localparam int FRAME_W    = SPI_CMD_W + SPI_DATA_W;
    localparam int CNT_W      = 5;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus SPI pins of the master, bundled for port connection.
// The slave modport is the view of whoever drives the host side and MISO.
interface spi_master_if #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
);
    logic              start;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  start, cmd, din, MISO,
        output busy, done, dout, SS_n, MOSI
    );

    modport slave (
        output start, cmd, din, MISO,
        input  busy, done, dout, SS_n, MOSI
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Shared TX/RX shift register: parallel load, left shift with serial-in at the LSB.
// o_par presents the received word including the bit currently on i_sin.
module spi_shift_reg #(
    parameter int W  = 10,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_val,
    input  logic          i_shift,
    input  logic          i_sin,
    output logic          o_msb,
    output logic [PW-1:0] o_par
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_sin};
        end
    end

    assign o_msb = r_q[W-1];
    assign o_par = {r_q[PW-2:0], i_sin};

endmodule

// File: rtl/spi_master.sv
// SPI master: sends a {cmd,din} frame MSB first, then for rd-data waits RD_LAT
// cycles and captures an 8-bit MISO response.
//
// state | meaning
// IDLE  | SS_n high, waiting for start
// SEL   | slave selected, first bit presented
// SHIFT | remaining frame bits on MOSI
// WAIT  | rd-data turnaround before the first MISO sample
// RECV  | sampling MISO response bits
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int CMD_W  = SPI_CMD_W,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    localparam int FRM_W = CMD_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(FRM_W - 1);
    localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_RECV  = CNT_W'(DATA_W - 2);

    spi_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_ss_n, w_ss_n_nxt;
    logic              r_mosi, w_mosi_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_rd, w_rd_nxt;
    logic [DATA_W-1:0] r_dout, w_dout_nxt;

    logic              w_load, w_shift, w_sin, w_msb;
    logic [DATA_W-1:0] w_par;

    spi_shift_reg #(
        .W  (FRM_W),
        .PW (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val ({bus.cmd, bus.din}),
        .i_shift    (w_shift),
        .i_sin      (w_sin),
        .o_msb      (w_msb),
        .o_par      (w_par)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = ST_SEL;
            ST_SEL:   w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == '0) w_state_nxt = r_rd ? ST_WAIT : ST_IDLE;
            ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_RECV;
            ST_RECV:  if (r_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The first MISO sample is taken on the edge that leaves WAIT.
    always_comb begin
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_sin      = 1'b0;
        w_cnt_nxt  = r_cnt;
        w_ss_n_nxt = r_ss_n;
        w_mosi_nxt = r_mosi;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        w_rd_nxt   = r_rd;
        w_dout_nxt = r_dout;
        case (r_state)
            ST_IDLE: begin
                w_ss_n_nxt = 1'b1;
                w_mosi_nxt = 1'b0;
                if (bus.start) begin
                    w_load     = 1'b1;
                    w_ss_n_nxt = 1'b0;
                    w_mosi_nxt = bus.cmd[CMD_W-1];
                    w_busy_nxt = 1'b1;
                    w_rd_nxt   = (bus.cmd == CMD_RD_DATA);
                end
            end
            ST_SEL: begin
                w_shift    = 1'b1;
                w_mosi_nxt = w_msb;
                w_cnt_nxt  = CNT_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt != '0) begin
                    w_shift    = 1'b1;
                    w_mosi_nxt = w_msb;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_mosi_nxt = 1'b0;
                    if (r_rd) begin
                        w_cnt_nxt = CNT_WAIT;
                    end else begin
                        w_ss_n_nxt = 1'b1;
                        w_done_nxt = 1'b1;
                        w_busy_nxt = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift   = 1'b1;
                    w_sin     = bus.MISO;
                    w_cnt_nxt = CNT_RECV;
                end
            end
            ST_RECV: begin
                w_shift = 1'b1;
                w_sin   = bus.MISO;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_dout_nxt = w_par;
                    w_ss_n_nxt = 1'b1;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_ss_n <= 1'b1;
            r_mosi <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_rd   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ss_n <= w_ss_n_nxt;
            r_mosi <= w_mosi_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_rd   <= w_rd_nxt;
            r_dout <= w_dout_nxt;
        end
    end

    assign bus.SS_n = r_ss_n;
    assign bus.MOSI = r_mosi;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dout = r_dout;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed frames from the test plan plus
// randomized frames, each compared against a per-frame timing/content model.
module tb_spi_master;
    import spi_pkg::*;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] exp_dout = 8'h00;

    spi_master_if #(.DATA_W(8), .CMD_W(2)) bus ();

    spi_master #(
        .DATA_W (8),
        .CMD_W  (2),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One frame, observed cycle by cycle from the accept edge (t=0 is the cycle after it).
    // SS_n falls on the accept edge and rises on the edge that ends the frame, where
    // done is raised; a write frame ends 11 edges after accept, a rd-data frame on its
    // 8th MISO sample edge, i.e. 10+RD_LAT+8 edges after accept.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m,
                             input bit keep, input int pulse);
        int len, lowcnt, busycnt, donecnt, done_t, extra, ovl, hold, first_s;
        logic [9:0] frame, mw;
        logic m0, sst;
        logic [7:0] dout_at;
        bit rd;
        rd      = (c == CMD_RD_DATA);
        len     = rd ? 10 + RD_LAT + 8 : 11;
        first_s = 10 + RD_LAT;
        frame   = {c, d};
        mw = '0; m0 = 1'b0; sst = 1'b0; dout_at = '0;
        lowcnt = 0; busycnt = 0; donecnt = 0; done_t = -1; extra = 0; ovl = 0; hold = 0;
        bus.start = 1'b1;
        bus.cmd   = c;
        bus.din   = d;
        for (int t = 0; t <= len; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                bus.cmd = 2'($urandom);
                bus.din = 8'($urandom);
            end
            if (!keep) bus.start = (t == pulse);
            if (!bus.SS_n) lowcnt++;
            if (bus.busy) busycnt++;
            if (bus.done) begin donecnt++; done_t = t; end
            if (bus.done && bus.busy) ovl++;
            if (t == 0) m0 = bus.MOSI;
            if (t >= 1 && t <= 10) mw = {mw[8:0], bus.MOSI};
            if (t >= 11 && bus.MOSI) extra++;
            if (t < len && bus.dout !== exp_dout) hold++;
            if (t == len) begin dout_at = bus.dout; sst = bus.SS_n; end
            if (t >= first_s && t < first_s + 8) bus.MISO = m[7 - (t - first_s)];
            else bus.MISO = 1'($urandom);
        end
        if (rd) exp_dout = m;
        chk("ss_low_len", 32'(lowcnt), 32'(len));
        chk("busy_len",   32'(busycnt), 32'(len));
        chk("done_count", 32'(donecnt), 32'd1);
        chk("done_time",  32'(done_t), 32'(len));
        chk("ss_at_done", 32'(sst), 32'd1);
        chk("mosi_first", 32'(m0), 32'(c[1]));
        chk("mosi_bits",  32'(mw), 32'(frame));
        chk("mosi_tail",  32'(extra), 32'd0);
        chk("done_busy",  32'(ovl), 32'd0);
        chk("dout_hold",  32'(hold), 32'd0);
        chk("dout",       32'(dout_at), 32'(exp_dout));
        if (!keep) begin
            @(posedge clk); #1;
            chk("idle_after", 32'({bus.busy, bus.SS_n, bus.done}), 32'(3'b010));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] c;
        logic [7:0] d, m;
        bit keep;
        int pulse;
        bus.start = 1'b0;
        bus.cmd   = 2'b00;
        bus.din   = 8'h00;
        bus.MISO  = 1'b0;
        #12;
        chk("rst_ss_n", 32'(bus.SS_n), 32'd1);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run_frame(CMD_WR_ADDR, 8'h3A, 8'h00, 1'b0, -1);
        run_frame(CMD_WR_DATA, 8'hC5, 8'h00, 1'b0, -1);
        run_frame(CMD_RD_DATA, 8'h00, 8'h96, 1'b0, -1);
        run_frame(CMD_RD_ADDR, 8'h55, 8'h00, 1'b1, -1);
        run_frame(CMD_WR_DATA, 8'hA3, 8'h00, 1'b0, -1);
        run_frame(CMD_RD_DATA, 8'hFF, 8'h5C, 1'b0, 5);

        for (int i = 0; i < 12; i++) begin
            c     = 2'($urandom);
            d     = 8'($urandom);
            m     = 8'($urandom);
            keep  = (i < 11) && ($urandom_range(0, 1) == 1);
            pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : -1;
            run_frame(c, d, m, keep, pulse);
        end

        // Abort a write frame while its 5th bit is on MOSI.
        bus.start = 1'b1;
        bus.cmd   = CMD_WR_ADDR;
        bus.din   = 8'h3A;
        for (int t = 0; t <= 5; t++) begin
            @(posedge clk); #1;
            if (t == 0) bus.start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        exp_dout = 8'h00;
        chk("abort_ss_n", 32'(bus.SS_n), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_mosi", 32'(bus.MOSI), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_dout", 32'(bus.dout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_hold", 32'({bus.busy, bus.SS_n, bus.done}), 32'(3'b010));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", 32'({bus.busy, bus.SS_n, bus.done}), 32'(3'b010));
        run_frame(CMD_WR_ADDR, 8'h3A, 8'h00, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
